hm10_status_tx: RTL and testbench
=================================

Name: hm10_status_tx

Overview:
- UART transmitter (8N1) that reports system status to the phone app through the HM-10 BT module's RX pin.
- Return path for the existing HM-10 receive path.
- Sends a 6-byte ASCII frame [MODE|-|-|POS|CR|LF], e.g. "A--4\r\n", whenever mode or servo position changes, and once after reset.
- Sits in the top level beside the receiver, servo PWM and display blocks; consumes the same sel_modo/posi signals.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 5208 at defaults).
- REPORT_MS, 1000, period of unsolicited report; used only with PERIODIC_REPORT_EN.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-low reset.
- sel_modo  input  1  0 = mode A, 1 = mode B.
- posi  input  3  current servo position, valid 1..5.
- send_req  input  1  one-cycle pulse forcing a report.
- tx  output  1  serial line to HM-10 RXD, idle high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse after the last stop bit of a frame.

Behaviour:
- Reset (RESET=0 at a clock edge):
  - tx=1, busy=0, frame_done=0.
  - All counters zero; both FSMs idle.
  - Snapshot valid flag cleared.
  - Effective on the next edge even mid-bit. A truncated byte is abandoned and never resumed.
- Power-on report: the first edge with RESET=1 sees an invalid snapshot and starts a frame. The start bit appears on tx 2 cycles after reset release.
- Trigger: a frame starts when the sequencer is idle and any of these holds:
  - {sel_modo,posi} differs from the snapshot;
  - snapshot is invalid;
  - send_req is pending.
- Frame start: latch {sel_modo,posi} into the snapshot and set valid. Later input changes do not alter a frame in flight.
- Frame bytes, in order:
  - mode: 0x41 'A' / 0x42 'B';
  - 0x2D, 0x2D;
  - position: 0x30+posi for posi 1..5, else 0x3F '?';
  - 0x0D, 0x0A.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Byte FSM states:
  - B_IDLE -> B_START on start strobe (byte latched).
  - B_START -> B_DATA after CLKS_PER_BIT cycles.
  - B_DATA (bit index 0..7) -> B_STOP after the 8th bit.
  - B_STOP -> B_IDLE after CLKS_PER_BIT cycles. Asserts byte_done for one cycle.
- Frame FSM states:
  - F_IDLE -> F_SEND on trigger.
  - F_SEND issues byte k and waits for byte_done.
  - k increments 0..5; after k=5 completes -> F_DONE.
  - F_DONE pulses frame_done and returns to F_IDLE.
  - Bytes are back-to-back: next start bit begins 1 cycle after the previous stop bit ends.
- Timing: frame length = 60*CLKS_PER_BIT + 7 cycles ±1. The bench checks per-bit timing exactly and frame length within tolerance.
- busy: high from the trigger edge through the frame_done cycle inclusive.
- Events during a frame:
  - send_req sets a pending flag; multiple requests collapse into one.
  - Input changes are not queued. After frame_done, the trigger compare uses current inputs, so only the latest value is reported.
- Simultaneous send_req and input change: one frame.
- Inputs are assumed synchronous to CLK; they are already registered upstream.

Optional Feature:
- PERIODIC_REPORT_EN defined:
  - A ms-prescaled counter raises the pending flag every REPORT_MS ms.
  - The counter restarts at every frame start, so a change-driven frame postpones the periodic report.
- Not defined: the counter logic is absent; reports occur only on change, reset or send_req.

Decomposition:
- Shared package/header:
  - ASCII constants (CHAR_A, CHAR_B, CHAR_DASH, CHAR_ZERO, CHAR_QMARK, CHAR_CR, CHAR_LF);
  - FRAME_LEN=6;
  - byte and frame state encodings.
- One sub-module, uart_tx_byte (CLK, RESET, start, data[7:0], tx, busy, byte_done), containing the byte FSM and baud counter.
- The top of this block holds the frame sequencer, snapshot, pending flag and optional periodic timer.

Test Plan (CLK_HZ=1000000, BAUD=100000, so 10 clocks/bit):
- Reset release with sel_modo=0, posi=3:
  - tx falls 2 cycles later;
  - decoded bytes 41 2D 2D 33 0D 0A;
  - frame_done pulses once; busy then low.
- Idle with no input change for 5000 cycles -> tx stays 1, no frame.
- Change to sel_modo=1, posi=5:
  - frame 42 2D 2D 35 0D 0A;
  - every bit exactly 10 cycles, LSB first.
- posi: 2 -> 4 -> 1 mid-frame:
  - current frame completes unchanged;
  - exactly one further frame follows, with byte 3 = 0x31.
- posi=7 -> byte 3 = 0x3F. Three send_req pulses during a frame -> exactly one extra identical frame.
- RESET low during bit 4 of byte 2:
  - tx=1 on the next edge, busy=0;
  - after release, a fresh full frame starts from byte 0.

Source files
------------

// File: rtl/hm10_status_tx_pkg.sv
// Shared ASCII constants, frame length, FSM encodings and the frame byte mux
// for the HM-10 status transmitter.
package hm10_status_tx_pkg;

  localparam logic [7:0] CHAR_A     = 8'h41;
  localparam logic [7:0] CHAR_B     = 8'h42;
  localparam logic [7:0] CHAR_DASH  = 8'h2D;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_QMARK = 8'h3F;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  localparam int FRAME_LEN = 6;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} b_state_t;
  typedef enum logic [1:0] {F_IDLE, F_SEND, F_DONE} f_state_t;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic       mode,
                                            input logic [2:0] pos);
    logic [7:0] b;
    case (idx)
      3'd0:       b = mode ? CHAR_B : CHAR_A;
      3'd1, 3'd2: b = CHAR_DASH;
      3'd3:       b = (pos >= 3'd1 && pos <= 3'd5) ? CHAR_ZERO + {5'd0, pos} : CHAR_QMARK;
      3'd4:       b = CHAR_CR;
      default:    b = CHAR_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/hm10_status_tx_if.sv
// Status/serial bundle between the system top level and the HM-10 status
// transmitter: inputs to report, serial line and frame progress.
interface hm10_status_tx_if;
  logic       sel_modo;
  logic [2:0] posi;
  logic       send_req;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (output sel_modo, posi, send_req, input tx, busy, frame_done);
  modport slave  (input sel_modo, posi, send_req, output tx, busy, frame_done);
endinterface

// File: rtl/hm10_status_tx_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each held
// CLKS_PER_BIT cycles; byte_done fires in the last stop-bit cycle.
//
// state   | meaning
// B_IDLE  | line high, waiting for start strobe
// B_START | driving start bit (0)
// B_DATA  | driving data bit bit_idx
// B_STOP  | driving stop bit (1)
module uart_tx_byte
  import hm10_status_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LOAD = CW'(CLKS_PER_BIT - 1);

  b_state_t      state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          tc;

  assign tc = (cnt == '0);

  always_ff @(posedge CLK) begin
    if (!RESET) state <= B_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      B_IDLE:  if (start) state_nxt = B_START;
      B_START: if (tc) state_nxt = B_DATA;
      B_DATA:  if (tc && bit_idx == 3'd7) state_nxt = B_STOP;
      B_STOP:  if (tc) state_nxt = B_IDLE;
      default: state_nxt = B_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != B_IDLE);
    byte_done = (state == B_STOP) && tc;
  end

  // tx is registered so the line changes exactly on bit boundaries
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        B_IDLE: begin
          if (start) begin
            shreg   <= data;
            cnt     <= LOAD;
            bit_idx <= '0;
            tx_q    <= 1'b0;
          end
        end
        B_START: begin
          if (tc) begin
            cnt   <= LOAD;
            tx_q  <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        B_DATA: begin
          if (tc) begin
            cnt     <= LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx_q <= 1'b1;
            end else begin
              tx_q  <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        B_STOP: begin
          if (!tc) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/hm10_status_tx.sv
// HM-10 status reporter: sends "<A|B>--<pos>\r\n" on mode/position change,
// after reset and on request. Define PERIODIC_REPORT_EN for a REPORT_MS report.
//
// state  | meaning
// F_IDLE | waiting for change, invalid snapshot or pending request
// F_SEND | serializing byte k of the frame
// F_DONE | frame_done pulse, back to idle
module hm10_status_tx
  import hm10_status_tx_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 9600,
  parameter int REPORT_MS = 1000
) (
  input logic             CLK,
  input logic             RESET,
  hm10_status_tx_if.slave status
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  f_state_t   f_state, f_state_nxt;
  logic [2:0] k;
  logic       snap_mode;
  logic [2:0] snap_pos;
  logic       snap_valid;
  logic       pending;
  logic       changed;
  logic       trig;
  logic       frame_start;
  logic       tick;
  logic       byte_start;
  logic       byte_busy;
  logic       byte_done;
  logic [7:0] byte_data;
  logic       tx_line;
  logic       busy;
  logic       frame_done;

  assign changed     = ({status.sel_modo, status.posi} != {snap_mode, snap_pos});
  assign trig        = changed || !snap_valid || pending || status.send_req;
  assign frame_start = (f_state == F_IDLE) && trig;

  always_ff @(posedge CLK) begin
    if (!RESET) f_state <= F_IDLE;
    else        f_state <= f_state_nxt;
  end

  always_comb begin
    f_state_nxt = f_state;
    case (f_state)
      F_IDLE:  if (trig) f_state_nxt = F_SEND;
      F_SEND:  if (byte_done && k == 3'(FRAME_LEN - 1)) f_state_nxt = F_DONE;
      F_DONE:  f_state_nxt = F_IDLE;
      default: f_state_nxt = F_IDLE;
    endcase
  end

  // a new byte is issued the cycle after the previous one returns to idle
  always_comb begin
    byte_start = (f_state == F_SEND) && !byte_busy;
    busy       = (f_state != F_IDLE);
    frame_done = (f_state == F_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      k          <= '0;
      snap_mode  <= 1'b0;
      snap_pos   <= '0;
      snap_valid <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (frame_start) begin
        k          <= '0;
        snap_mode  <= status.sel_modo;
        snap_pos   <= status.posi;
        snap_valid <= 1'b1;
      end else if (f_state == F_SEND && byte_done) begin
        k <= k + 3'd1;
      end
      // requests arriving during a frame collapse into one follow-up frame
      if (frame_start)                 pending <= 1'b0;
      else if (status.send_req || tick) pending <= 1'b1;
    end
  end

`ifdef PERIODIC_REPORT_EN
  localparam int            CLKS_PER_MS = CLK_HZ / 1000;
  localparam int            PW          = $clog2(CLKS_PER_MS + 1);
  localparam int            MW          = $clog2(REPORT_MS + 1);
  localparam logic [PW-1:0] PRE_LOAD    = PW'(CLKS_PER_MS - 1);
  localparam logic [MW-1:0] MS_LOAD     = MW'(REPORT_MS - 1);

  logic [PW-1:0] pre_cnt;
  logic [MW-1:0] ms_cnt;

  // restarting on every frame lets change-driven frames postpone the report
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (frame_start) begin
      pre_cnt <= PRE_LOAD;
      ms_cnt  <= MS_LOAD;
    end else if (pre_cnt != '0) begin
      pre_cnt <= pre_cnt - PW'(1);
    end else begin
      pre_cnt <= PRE_LOAD;
      ms_cnt  <= (ms_cnt == '0) ? MS_LOAD : ms_cnt - MW'(1);
    end
  end

  assign tick = (pre_cnt == '0) && (ms_cnt == '0);
`else
  logic unused_report_ms;
  assign unused_report_ms = ^32'(REPORT_MS);
  assign tick             = 1'b0;
`endif

  assign byte_data = frame_byte(k, snap_mode, snap_pos);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (byte_start),
    .data      (byte_data),
    .tx        (tx_line),
    .busy      (byte_busy),
    .byte_done (byte_done)
  );

  assign status.tx         = tx_line;
  assign status.busy       = busy;
  assign status.frame_done = frame_done;

endmodule

// File: tb/tb_hm10_status_tx.sv
// Bench for hm10_status_tx at 10 clocks/bit: decodes the serial line and
// compares each frame against an ASCII model of the reported inputs.
module tb_hm10_status_tx;

  localparam int C         = 10;
  localparam int FRAME_CYC = 60 * C + 7;

  logic clk = 1'b0;
  logic rst;

  hm10_status_tx_if bus ();

  hm10_status_tx #(
    .CLK_HZ   (1000000),
    .BAUD     (100000),
    .REPORT_MS(1000)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .status(bus.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   ncyc   = 0;
  int   t_busy = 0;
  int   t_done = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    ncyc   <= ncyc + 1;
    busy_q <= bus.busy;
    if (bus.busy === 1'b1 && busy_q !== 1'b1) t_busy <= ncyc;
    if (bus.frame_done === 1'b1) t_done <= ncyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] model_frame(input logic m, input logic [2:0] p);
    logic [7:0] pc;
    pc = (p >= 3'd1 && p <= 3'd5) ? 8'h30 + {5'd0, p} : 8'h3F;
    return {(m ? 8'h42 : 8'h41), 8'h2D, 8'h2D, pc, 8'h0D, 8'h0A};
  endfunction

  task automatic pulse_req();
    bus.send_req = 1'b1;
    @(negedge clk);
    bus.send_req = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  // Receives one frame starting at (or waiting for) the first start bit.
  task automatic check_frame(input string tag, input logic [47:0] exp);
    logic [47:0] got;
    logic [9:0]  sym;
    bit          tim_ok;
    int          t;
    int          len;
    int          len_obs;
    got    = '0;
    sym    = '0;
    tim_ok = 1'b1;
    t      = 0;
    while (bus.tx !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " start"}, 64'(bus.tx === 1'b0), 64'd1);
    if (bus.tx !== 1'b0) return;
    for (int b = 0; b < 6; b++) begin
      if (b > 0) begin
        if (bus.tx !== 1'b1) tim_ok = 1'b0;
        @(negedge clk);
        if (bus.tx !== 1'b0) tim_ok = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
        sym[i] = bus.tx;
        for (int c = 1; c < C; c++) begin
          @(negedge clk);
          if (bus.tx !== sym[i]) tim_ok = 1'b0;
        end
        @(negedge clk);
      end
      if (sym[0] !== 1'b0 || sym[9] !== 1'b1) tim_ok = 1'b0;
      got[47-8*b -: 8] = sym[8:1];
    end
    chk({tag, " bytes"}, 64'(got), 64'(exp));
    chk({tag, " bit timing"}, 64'(tim_ok), 64'd1);
    chk({tag, " frame_done"}, 64'(bus.frame_done), 64'd1);
    @(negedge clk);
    chk({tag, " done/busy after"}, 64'({bus.frame_done, bus.busy}), 64'd0);
    len     = t_done - t_busy + 1;
    len_obs = (len >= FRAME_CYC - 1 && len <= FRAME_CYC + 1) ? FRAME_CYC : len;
    chk({tag, " length"}, 64'(len_obs), 64'(FRAME_CYC));
  endtask

  initial begin
    logic       m;
    logic [2:0] p;
    logic [3:0] r;

    rst          = 1'b0;
    m            = 1'b0;
    p            = 3'd3;
    bus.sel_modo = m;
    bus.posi     = p;
    bus.send_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset tx", 64'(bus.tx), 64'd1);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset frame_done", 64'(bus.frame_done), 64'd0);

    rst = 1'b1;
    @(negedge clk);
    chk("release+1 tx", 64'(bus.tx), 64'd1);
    chk("release+1 busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("release+2 tx", 64'(bus.tx), 64'd0);
    check_frame("power-on", model_frame(m, p));
    expect_quiet("idle 5000", 5000);

    m = 1'b1; p = 3'd5;
    bus.sel_modo = m; bus.posi = p;
    check_frame("B5", model_frame(m, p));
    expect_quiet("after B5", 100);

    p = 3'd2;
    bus.posi = p;
    fork
      check_frame("mid first", model_frame(1'b1, 3'd2));
      begin
        repeat (150) @(negedge clk);
        bus.posi = 3'd4;
        repeat (150) @(negedge clk);
        bus.posi = 3'd1;
      end
    join
    p = 3'd1;
    check_frame("mid latest", model_frame(m, p));
    expect_quiet("after mid", 700);

    p = 3'd7;
    bus.posi = p;
    fork
      check_frame("qmark", model_frame(m, p));
      begin
        repeat (100) @(negedge clk);
        pulse_req();
        repeat (150) @(negedge clk);
        pulse_req();
        repeat (150) @(negedge clk);
        pulse_req();
      end
    join
    check_frame("req repeat", model_frame(m, p));
    expect_quiet("after req", 700);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_req();
      end else begin
        do r = 4'($urandom); while (r == {m, p});
        {m, p} = r;
        bus.sel_modo = m;
        bus.posi     = p;
      end
      check_frame("random", model_frame(m, p));
      expect_quiet("random quiet", 50);
    end

    m = ~m;
    bus.sel_modo = m;
    bus.send_req = 1'b1;
    @(negedge clk);
    bus.send_req = 1'b0;
    check_frame("req+change", model_frame(m, p));
    expect_quiet("after req+change", 700);

    bus.send_req = 1'b1;
    @(negedge clk);
    bus.send_req = 1'b0;
    repeat (257) @(negedge clk);
    chk("byte2 bit4 tx", 64'(bus.tx), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset tx", 64'(bus.tx), 64'd1);
    chk("mid reset busy", 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("re-release+1 tx", 64'(bus.tx), 64'd1);
    chk("re-release+1 busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("re-release+2 tx", 64'(bus.tx), 64'd0);
    check_frame("after reset", model_frame(m, p));
    expect_quiet("final quiet", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
